de0_slider_debounce: RTL and testbench

Input conditioning stage for the DE0 slider switches. Takes the raw, asynchronous 4-bit switch vector and synchronizes it into the clock domain. Debounces it and drives the clean value into the `din` input of the downstream `de0_led_slider` LED/FND decoder. Also reports each accepted change as a single-cycle pulse with a per-bit change mask.

---
 rtl/de0_slider_debounce.sv | 128 ++++++++++++
 tb/tb_de0_slider_debounce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/de0_slider_debounce.sv
// Slider switch conditioner: 2-FF synchronizer, debounce and change-pulse generation.
// Build option DB_ALL_STABLE_EN selects whole-vector debounce instead of per-bit debounce.
module de0_slider_debounce #(
   parameter int unsigned DB_CNT = 500000,
   parameter int unsigned CNT_W  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_in,
   output logic [3:0] dout,
   output logic       dout_chg,
   output logic [3:0] chg_mask
);

   localparam int unsigned NB = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

   logic [NB-1:0] s1;
   logic [NB-1:0] s2;
   logic [NB-1:0] upd_c;

   // two-stage synchronizer for the asynchronous switch inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

`ifdef DB_ALL_STABLE_EN

   logic [NB-1:0]    p;
   logic [CNT_W-1:0] vcnt;
   logic             mism_c;
   logic             moving_c;

   always_comb begin
      mism_c   = (s2 != dout);
      moving_c = (s2 != p);
      upd_c    = '0;
      if (mism_c && !moving_c && (vcnt == CNT_LAST))
         upd_c = s2 ^ dout;
   end

   // shared counter restarts whenever any synchronized bit moves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p    <= '0;
         vcnt <= '0;
      end else begin
         p <= s2;
         if (!mism_c || moving_c || (vcnt == CNT_LAST))
            vcnt <= '0;
         else
            vcnt <= vcnt + CNT_W'(1);
      end
   end

`else

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } state_t;

   state_t           state [NB];
   logic [CNT_W-1:0] cnt   [NB];

   always_comb begin
      upd_c = '0;
      for (int i = 0; i < NB; i++)
         upd_c[i] = (state[i] == ST_COUNT) && (s2[i] != dout[i]) && (cnt[i] == CNT_LAST);
   end

   // entering COUNT already counts the first mismatching cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB; i++) begin
            state[i] <= ST_STABLE;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            case (state[i])
               ST_STABLE: begin
                  if (s2[i] != dout[i]) begin
                     state[i] <= ST_COUNT;
                     cnt[i]   <= CNT_W'(1);
                  end else begin
                     cnt[i] <= '0;
                  end
               end
               ST_COUNT: begin
                  if ((s2[i] == dout[i]) || (cnt[i] == CNT_LAST)) begin
                     state[i] <= ST_STABLE;
                     cnt[i]   <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state[i] <= ST_STABLE;
                  cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

`endif

   // accepted bits flip dout; flags coincide with the new dout value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_chg <= 1'b0;
         chg_mask <= '0;
      end else begin
         dout     <= dout ^ upd_c;
         dout_chg <= |upd_c;
         chg_mask <= upd_c;
      end
   end

endmodule

// File: tb/tb_de0_slider_debounce.sv
// Scoreboard bench for de0_slider_debounce with DB_CNT=4, CNT_W=3.
module tb_de0_slider_debounce;

   localparam int unsigned DB_CNT = 4;
   localparam int unsigned CNT_W  = 3;
`ifdef DB_ALL_STABLE_EN
   localparam int LAT = DB_CNT + 2;
`else
   localparam int LAT = DB_CNT + 1;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_in;
   logic [3:0] dout;
   logic       dout_chg;
   logic [3:0] chg_mask;

   de0_slider_debounce #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_in    (sw_in),
      .dout     (dout),
      .dout_chg (dout_chg),
      .chg_mask (chg_mask)
   );

   typedef struct {
      int         cyc;
      logic [3:0] d;
      logic [3:0] m;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   int         errors  = 0;
   int         checks  = 0;
   int         cyc     = 0;
   int         n_pulse = 0;
   logic [3:0] cur_dout = 4'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // pops one expectation per pulse; between pulses dout must hold and mask stay 0
   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_chg) begin
            n_pulse++;
            if (sb.size() == 0) begin
               check("spurious_chg", 32'(chg_mask), 32'(0));
            end else begin
               mon_e = sb.pop_front();
               check("chg_cycle", 32'(cyc), 32'(mon_e.cyc));
               check("chg_dout", 32'(dout), 32'(mon_e.d));
               check("chg_mask", 32'(chg_mask), 32'(mon_e.m));
               cur_dout = mon_e.d;
            end
         end else begin
            check("hold_dout", 32'(dout), 32'(cur_dout));
            check("idle_mask", 32'(chg_mask), 32'(0));
         end
      end
   end

   task automatic drive(input logic [3:0] v, output int e0);
      @(negedge clk);
      sw_in = v;
      e0 = cyc + 1;
   endtask

   task automatic expect_chg(input int c, input logic [3:0] d, input logic [3:0] m);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      e.m   = m;
      sb.push_back(e);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'(0));
      sb.delete();
      rst_n    = 1'b0;
      sw_in    = 4'h0;
      cur_dout = 4'h0;
      repeat (n) begin
         @(negedge clk);
         check("rst_dout", 32'(dout), 32'(0));
         check("rst_chg", 32'(dout_chg), 32'(0));
         check("rst_mask", 32'(chg_mask), 32'(0));
      end
      rst_n = 1'b1;
   endtask

   initial begin
      int         e0;
      int         r;
      logic [3:0] prev;

      rst_n = 1'b0;
      sw_in = 4'h0;

      // reset hold
      apply_reset(20);
      repeat (5) @(posedge clk);

      // single step 0 -> 9
      drive(4'h9, e0);
      expect_chg(e0 + LAT, 4'h9, 4'h9);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("step_dout", 32'(dout), 32'(4'h9));

      // 3-cycle glitch on bit0
      apply_reset(2);
      drive(4'h1, e0);
      repeat (3) @(posedge clk);
      drive(4'h0, r);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("glitch_dout", 32'(dout), 32'(0));

      // staggered bit3 then bit1
      apply_reset(2);
      drive(4'h8, e0);
`ifdef DB_ALL_STABLE_EN
      expect_chg(e0 + 8, 4'hA, 4'hA);
`else
      expect_chg(e0 + 5, 4'h8, 4'h8);
      expect_chg(e0 + 7, 4'hA, 4'h2);
`endif
      repeat (2) @(posedge clk);
      drive(4'hA, r);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("stagger_dout", 32'(dout), 32'(4'hA));

      // reset during the count
      apply_reset(2);
      drive(4'h5, e0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_dout", 32'(dout), 32'(0));
      check("midrst_chg", 32'(dout_chg), 32'(0));
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      cur_dout = 4'h0;
      expect_chg(cyc + 1 + LAT, 4'h5, 4'h5);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("midrst_final", 32'(dout), 32'(4'h5));

      // sweep 0..9
      apply_reset(2);
      repeat (9) @(posedge clk);
      n_pulse = 0;
      prev = 4'h0;
      for (int v = 1; v <= 9; v++) begin
         drive(4'(v), e0);
         expect_chg(e0 + LAT, 4'(v), prev ^ 4'(v));
         prev = 4'(v);
         repeat (9) @(posedge clk);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sweep_pulses", 32'(n_pulse), 32'(9));
      check("sweep_dout", 32'(dout), 32'(4'h9));
      check("sb_final", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
